// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with a prefetch queue ahead of the IF/ID register.
// Optional bypass into IF/ID when the queue is empty: FETCH_BYPASS_EN.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       StallD,
  input  logic                       FlushD,
  input  logic [1:0]                 PCSrcE,
  input  logic [XLEN-1:0]            PCTargetE,
  input  logic [XLEN-1:0]            ALUResultE,
  output logic [XLEN-1:0]            ImemAddr,
  input  logic [31:0]                ImemRdata,
  input  logic                       ImemReady,
  output logic [31:0]                InstrD,
  output logic [XLEN-1:0]            PCD,
  output logic [XLEN-1:0]            PCPlus4D,
  output logic                       ValidD,
  output logic [$clog2(DEPTH+1)-1:0] QueueCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_pcf;
  logic [31:0]     r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;

  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc4_d;
  logic            r_valid_d;

  logic            w_redirect;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_fetch;
  logic            w_bypass;
  logic            w_push;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pcf4;
  logic [XLEN-1:0] w_head_pc;

  assign w_redirect = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_pop      = !StallD && !FlushD && !w_redirect && !w_empty;
  assign w_fetch    = ImemReady && !w_redirect && (!w_full || w_pop);
`ifdef FETCH_BYPASS_EN
  assign w_bypass   = w_empty && w_fetch && !StallD && !FlushD;
`else
  assign w_bypass   = 1'b0;
`endif
  assign w_push     = w_fetch && !w_bypass;
  assign w_pcf4     = r_pcf + XLEN'(4);
  assign w_head_pc  = r_q_pc[r_rp];
  assign w_target   = (PCSrcE == 2'b01) ? PCTargetE
                                        : {ALUResultE[XLEN-1:1], 1'b0};

  assign ImemAddr   = r_pcf;
  assign InstrD     = r_instr_d;
  assign PCD        = r_pc_d;
  assign PCPlus4D   = r_pc4_d;
  assign ValidD     = r_valid_d;
  assign QueueCount = r_cnt;

  // PC register: redirect wins, otherwise advance on each fetch
  always_ff @(posedge CLK) begin
    if (RST)             r_pcf <= RESET_PC;
    else if (w_redirect) r_pcf <= w_target;
    else if (w_fetch)    r_pcf <= w_pcf4;
  end

  // Queue storage: written only on push, no reset needed
  always_ff @(posedge CLK) begin
    if (w_push && !RST) begin
      r_q_instr[r_wp] <= ImemRdata;
      r_q_pc[r_wp]    <= r_pcf;
    end
  end

  // Queue pointers and occupancy; redirect discards speculative entries
  always_ff @(posedge CLK) begin
    if (RST || w_redirect) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // IF/ID register: redirect > flush > stall > pop/bypass > bubble
  always_ff @(posedge CLK) begin
    if (RST || w_redirect || FlushD) begin
      r_instr_d <= '0;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
      r_valid_d <= 1'b0;
    end else if (StallD) begin
      r_valid_d <= r_valid_d;
    end else if (w_pop) begin
      r_instr_d <= r_q_instr[r_rp];
      r_pc_d    <= w_head_pc;
      r_pc4_d   <= w_head_pc + XLEN'(4);
      r_valid_d <= 1'b1;
    end else if (w_bypass) begin
      r_instr_d <= ImemRdata;
      r_pc_d    <= r_pcf;
      r_pc4_d   <= w_pcf4;
      r_valid_d <= 1'b1;
    end else begin
      r_instr_d <= '0;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
      r_valid_d <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage (DEPTH=4, RESET_PC=0x100).
// Decode latency follows FETCH_BYPASS_EN when it is defined for the build.
module tb_fetch_queue_stage;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        StallD;
  logic        FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemReady;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [2:0]  QueueCount;

  int n_chk = 0;
  int n_bad = 0;

  fetch_queue_stage #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h100)
  ) dut (
    .CLK(CLK), .RST(RST), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .ImemReady(ImemReady),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .QueueCount(QueueCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  assign ImemRdata = mem(ImemAddr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_addr"},  ImemAddr, 32'h100);
    check({tag, "_cnt"},   32'(QueueCount), 0);
    check({tag, "_instr"}, InstrD, 0);
    check({tag, "_pcd"},   PCD, 0);
    check({tag, "_pc4"},   PCPlus4D, 0);
    check({tag, "_valid"}, 32'(ValidD), 0);
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc);
    check({tag, "_pcd"},   PCD, pc);
    check({tag, "_pc4"},   PCPlus4D, pc + 32'd4);
    check({tag, "_instr"}, InstrD, mem(pc));
    check({tag, "_valid"}, 32'(ValidD), 1);
  endtask

  initial begin
    RST = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
    PCTargetE = '0; ALUResultE = '0; ImemReady = 1'b1;
    tick(); tick();
    chk_reset("rst");

    RST = 1'b0;
    repeat (LAT) tick();
    for (int i = 0; i < 3; i++) begin
      chk_dec("seq", 32'h100 + 32'(4 * i));
      if (i < 2) tick();
    end

    StallD = 1'b1;
    repeat (8) tick();
    check("stall_cnt", 32'(QueueCount), 4);
    check("stall_addr", ImemAddr, 32'h11C);
    chk_dec("stall_hold", 32'h108);

    StallD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_dec("release", 32'h10C + 32'(4 * i));
    end

    ImemReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drain_addr", ImemAddr, 32'h13C);
      if (i < 4) begin
        chk_dec("drain", 32'h12C + 32'(4 * i));
        check("drain_cnt", 32'(QueueCount), 32'(3 - i));
      end else begin
        check("bubble_valid", 32'(ValidD), 0);
        check("bubble_instr", InstrD, 0);
        check("bubble_cnt", 32'(QueueCount), 0);
      end
    end

    ImemReady = 1'b1;
    StallD = 1'b1;
    repeat (3) tick();
    check("pre_br_cnt", 32'(QueueCount), 3);

    PCSrcE = 2'b01; PCTargetE = 32'h200;
    tick();
    check("br_cnt", 32'(QueueCount), 0);
    check("br_valid", 32'(ValidD), 0);
    check("br_addr", ImemAddr, 32'h200);
    PCSrcE = 2'b00; StallD = 1'b0;
    repeat (LAT) tick();
    chk_dec("br_tgt", 32'h200);

    PCSrcE = 2'b10; ALUResultE = 32'h305;
    tick();
    check("jalr_addr", ImemAddr, 32'h304);
    check("jalr_valid", 32'(ValidD), 0);
    PCSrcE = 2'b00;
    repeat (LAT) tick();
    chk_dec("jalr_tgt", 32'h304);
    tick();
    chk_dec("jalr_next", 32'h308);

    FlushD = 1'b1;
    tick();
    check("flush_valid", 32'(ValidD), 0);
    check("flush_instr", InstrD, 0);
    FlushD = 1'b0;
    tick();
    chk_dec("after_flush", 32'h30C);

    StallD = 1'b1;
    repeat (5) tick();
    check("full_cnt", 32'(QueueCount), 4);
    RST = 1'b1; FlushD = 1'b1;
    tick();
    chk_reset("rst2");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
